// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: FSM state encoding, score width and
// serve-direction constants.
package pong_pkg;

  localparam int unsigned SCORE_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the match sequencer and its surroundings (button, ball logic,
// score displays).
//   start            raw start push-button (asynchronous)
//   point_l/point_r  point levels from ball logic
//   score_l/score_r  per-player scores
//   ball_en/ball_rst/serve_dir  ball logic controls
//   game_over/winner match result
//   state            FSM state for debug LEDs
// slave modport: the sequencer. master modport: the environment driving it.
interface pong_match_ctrl_if;
  import pong_pkg::*;

  logic               start;
  logic               point_l;
  logic               point_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               ball_en;
  logic               ball_rst;
  logic               serve_dir;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport slave (
    input  start, point_l, point_r,
    output score_l, score_r, ball_en, ball_rst, serve_dir, game_over, winner, state
  );

  modport master (
    output start, point_l, point_r,
    input  score_l, score_r, ball_en, ball_rst, serve_dir, game_over, winner, state
  );

endinterface

// File: rtl/pong_debounce.sv
// Synchronous level debouncer: the output follows the input only after the input has
// differed from it for DB_CYC consecutive cycles.
//   cloco  clock          rset  asynchronous active-high reset
//   din    synchronized level in
//   dout   debounced level out
module pong_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic cloco,
  input  logic rset,
  input  logic din,
  output logic dout
);

  localparam int unsigned    CntW    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYC - 1);

  logic [CntW-1:0] cnt_q;
  logic            dout_q;

  always_ff @(posedge cloco or posedge rset) begin
    if (rset) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else if (din == dout_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      dout_q <= din;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: owns both score registers and sequences each rally
// (IDLE -> SERVE -> PLAY -> POINT/OVER). All outputs are registered.
//   cloco  clock
//   rset   asynchronous active-high reset
//   bus    pong_match_ctrl_if.slave (start, point inputs; scores, ball controls, status)
// Optional: define PONG_START_DEBOUNCE_EN to debounce the start button for DB_CYC cycles.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE = 5,
  parameter int unsigned PAUSE_CYC = 50_000_000,
  parameter int unsigned DB_CYC    = 1_000_000
) (
  input logic              cloco,
  input logic              rset,
  pong_match_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PAUSE_CYC - 1);
  localparam logic [SCORE_W-1:0] WinS = SCORE_W'(WIN_SCORE);

  if (WIN_SCORE < 1 || WIN_SCORE > 7 || PAUSE_CYC < 1 || DB_CYC < 1) begin : g_bad_param
    $error("pong_match_ctrl: parameter out of range");
  end

  // Start path: 2-flop synchronizer, optional debounce, rising-edge detect.
  logic sync1_q, sync2_q, start_lvl, start_prev_q, start_pulse;

`ifdef PONG_START_DEBOUNCE_EN
  pong_debounce #(
    .DB_CYC (DB_CYC)
  ) u_debounce (
    .cloco (cloco),
    .rset  (rset),
    .din   (sync2_q),
    .dout  (start_lvl)
  );
`else
  assign start_lvl = sync2_q;
`endif

  assign start_pulse = start_lvl & ~start_prev_q;

  // Point inputs are already synchronous; one register each for edge detection.
  logic pl_prev_q, pr_prev_q, pl_pulse, pr_pulse;
  assign pl_pulse = bus.point_l & ~pl_prev_q;
  assign pr_pulse = bus.point_r & ~pr_prev_q;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               dir_q, dir_d, winner_q, winner_d;
  logic               ball_en_q, ball_en_d, ball_rst_q, ball_rst_d, over_q, over_d;

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    unique case (state_q)
      IDLE: if (start_pulse) state_d = SERVE;
      SERVE: state_d = PLAY;
      PLAY: begin
        if (pl_pulse && pr_pulse) begin
          // Simultaneous points void the rally.
          state_d = POINT;
          cnt_d   = '0;
        end else if (pl_pulse) begin
          score_l_d = score_l_q + 1'b1;
          dir_d     = DIR_RIGHT;
          if (score_l_d == WinS) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else begin
            state_d = POINT;
            cnt_d   = '0;
          end
        end else if (pr_pulse) begin
          score_r_d = score_r_q + 1'b1;
          dir_d     = DIR_LEFT;
          if (score_r_d == WinS) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d = POINT;
            cnt_d   = '0;
          end
        end
      end
      POINT: begin
        if (cnt_q == CntLast) state_d = SERVE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      OVER: begin
        if (start_pulse) begin
          score_l_d = '0;
          score_r_d = '0;
          dir_d     = DIR_LEFT;
          state_d   = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered from the next state so they track it exactly.
    ball_en_d  = (state_d == PLAY);
    ball_rst_d = ~ball_en_d;
    over_d     = (state_d == OVER);
  end

  always_ff @(posedge cloco or posedge rset) begin
    if (rset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      start_prev_q <= 1'b0;
      pl_prev_q    <= 1'b0;
      pr_prev_q    <= 1'b0;
      state_q      <= IDLE;
      score_l_q    <= '0;
      score_r_q    <= '0;
      cnt_q        <= '0;
      dir_q        <= DIR_LEFT;
      winner_q     <= 1'b0;
      ball_en_q    <= 1'b0;
      ball_rst_q   <= 1'b1;
      over_q       <= 1'b0;
    end else begin
      sync1_q      <= bus.start;
      sync2_q      <= sync1_q;
      start_prev_q <= start_lvl;
      pl_prev_q    <= bus.point_l;
      pr_prev_q    <= bus.point_r;
      state_q      <= state_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      winner_q     <= winner_d;
      ball_en_q    <= ball_en_d;
      ball_rst_q   <= ball_rst_d;
      over_q       <= over_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.ball_en   = ball_en_q;
  assign bus.ball_rst  = ball_rst_q;
  assign bus.serve_dir = dir_q;
  assign bus.game_over = over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: randomized rallies against a rule-level match model. Each
// stimulus pushes the expected output snapshots (with the cycle they must appear) into a
// queue; a monitor pops one whenever the DUT outputs change.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  localparam int unsigned WIN   = 5;
  localparam int unsigned PAUSE = 4;
  localparam int unsigned DB    = 8;
`ifdef PONG_START_DEBOUNCE_EN
  localparam int START_LAT = 3 + DB;
`else
  localparam int START_LAT = 3;
`endif

  logic cloco = 1'b0;
  logic rset  = 1'b1;
  always #5 cloco = ~cloco;

  pong_match_ctrl_if bus();

  pong_match_ctrl #(
    .WIN_SCORE (WIN),
    .PAUSE_CYC (PAUSE),
    .DB_CYC    (DB)
  ) dut (
    .cloco (cloco),
    .rset  (rset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] sl;
    logic [2:0] sr;
    logic       dir;
    logic       go;
    logic       win;
    logic       en;
    logic       brst;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge cloco) cyc <= cyc + 1;

  // Match model: scores, serve direction, result and the phase of play.
  int     m_sl, m_sr;
  logic   m_dir, m_go, m_win;
  state_e m_phase;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic snap_t mk(input state_e st);
    snap_t s;
    s.st   = st;
    s.sl   = 3'(m_sl);
    s.sr   = 3'(m_sr);
    s.dir  = m_dir;
    s.go   = (st == OVER);
    s.win  = m_win;
    s.en   = (st == PLAY);
    s.brst = (st != PLAY);
    return s;
  endfunction

  task automatic push(input int c, input state_e st);
    exp_t e;
    e.cyc = c;
    e.s   = mk(st);
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_dir = 1'b0; m_go = 1'b0; m_win = 1'b0;
    m_phase = IDLE;
    q.delete();
  endtask

  // Monitor: any change of the visible outputs must match the next expected snapshot.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    prev = '0;
    forever begin
      @(negedge cloco);
      cur = {bus.state, bus.score_l, bus.score_r, bus.serve_dir, bus.game_over, bus.winner,
             bus.ball_en, bus.ball_rst};
      if (rset) begin
        prev = cur;
      end else if (cur != prev) begin
        if (q.size() == 0) begin
          chk("unexpected_change", int'(cur), int'(prev));
        end else begin
          e = q.pop_front();
          chk("snapshot", int'(cur), int'(e.s));
          chk("change_cycle", cyc, e.cyc);
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cloco);
      #1;
    end
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() != 0 && b < 200) begin
      tick(1);
      b++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, int'(bus.state), int'(IDLE));
    chk({tag, "_score_l"}, int'(bus.score_l), 0);
    chk({tag, "_score_r"}, int'(bus.score_r), 0);
    chk({tag, "_ball_en"}, int'(bus.ball_en), 0);
    chk({tag, "_ball_rst"}, int'(bus.ball_rst), 1);
    chk({tag, "_serve_dir"}, int'(bus.serve_dir), 0);
    chk({tag, "_game_over"}, int'(bus.game_over), 0);
    chk({tag, "_winner"}, int'(bus.winner), 0);
  endtask

  task automatic do_start();
    int k = cyc;
    bus.start = 1'b1;
    if (m_phase == IDLE || m_phase == OVER) begin
      if (m_phase == OVER) begin
        m_sl = 0; m_sr = 0; m_dir = 1'b0; m_go = 1'b0;
      end
      push(k + START_LAT, SERVE);
      push(k + START_LAT + 1, PLAY);
      m_phase = PLAY;
    end
    tick(START_LAT + 2);
    bus.start = 1'b0;
    tick(START_LAT + 2);
  endtask

  task automatic do_point(input logic l, input logic r, input int hold);
    int k = cyc;
    bus.point_l = l;
    bus.point_r = r;
    if (m_phase == PLAY && (l || r)) begin
      if (!(l && r)) begin
        if (l) begin m_sl++; m_dir = 1'b1; end
        else   begin m_sr++; m_dir = 1'b0; end
      end
      if (m_sl == WIN || m_sr == WIN) begin
        m_go = 1'b1;
        m_win = (m_sr == WIN);
        m_phase = OVER;
        push(k + 1, OVER);
      end else begin
        push(k + 1, POINT);
        push(k + 1 + PAUSE, SERVE);
        push(k + 2 + PAUSE, PLAY);
      end
    end
    tick(hold);
    bus.point_l = 1'b0;
    bus.point_r = 1'b0;
    tick(2);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, rr;
    bus.start = 1'b0; bus.point_l = 1'b0; bus.point_r = 1'b0;
    model_reset();
    tick(3);
    check_reset("por");
    rset = 1'b0;
    tick(2);

    // First serve, then a held left point that must score once.
    do_start();
    drain();
    do_point(1'b1, 1'b0, 10);
    drain();
    chk("held_point_score_l", int'(bus.score_l), m_sl);
    do_point(1'b1, 1'b1, 3);
    drain();
    do_start();  // ignored while playing
    drain();

    // Random rallies to the end of the match.
    guard = 0;
    while (m_phase == PLAY && guard < 200) begin
      rr = int'($urandom_range(0, 9));
      if (rr == 0)      do_point(1'b1, 1'b1, int'($urandom_range(1, 12)));
      else if (rr < 5)  do_point(1'b1, 1'b0, int'($urandom_range(1, 12)));
      else              do_point(1'b0, 1'b1, int'($urandom_range(1, 12)));
      drain();
      guard++;
    end
    do_point(1'b1, 1'b0, 2);  // ignored in OVER
    do_point(1'b0, 1'b1, 2);
    tick(3);
    chk("over_game_over", int'(bus.game_over), int'(m_go));
    chk("over_winner", int'(bus.winner), int'(m_win));
    do_start();
    drain();
    chk("restart_scores", int'({bus.score_l, bus.score_r}), 0);

    // Right player wins 5-0.
    repeat (WIN) begin
      do_point(1'b0, 1'b1, int'($urandom_range(1, 8)));
      drain();
    end
    chk("right_win_winner", int'(bus.winner), 1);
    chk("right_win_over", int'(bus.game_over), 1);
    do_start();
    drain();

    // Reach 3/2 and reset in the middle of the pause.
    do_point(1'b1, 1'b0, 1); drain();
    do_point(1'b1, 1'b0, 1); drain();
    do_point(1'b0, 1'b1, 1); drain();
    do_point(1'b0, 1'b1, 1); drain();
    do_point(1'b1, 1'b0, 1);
    chk("mid_point_state", int'(bus.state), int'(POINT));
    chk("mid_point_scores", int'({bus.score_l, bus.score_r}), int'({3'd3, 3'd2}));
    #2;
    rset = 1'b1;
    #1;
    q.delete();
    check_reset("async");
    tick(2);
    model_reset();
    rset = 1'b0;
    tick(2);

`ifdef PONG_START_DEBOUNCE_EN
    // Short glitch must not start the match.
    bus.start = 1'b1;
    tick(5);
    bus.start = 1'b0;
    tick(20);
    chk("glitch_state", int'(bus.state), int'(IDLE));
`endif

    do_start();
    drain();
    chk("final_ball_en", int'(bus.ball_en), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
